// File: rtl/pc_next_unit.sv
// Fetch PC register with j/jal/jr/beq/bne redirect resolution, stall-held redirects and a
// one-cycle fetch flush. Optional statistics counters are built when PC_PERF_CNT_EN is defined.
module pc_next_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       JUMP_W   = 26,
  parameter int unsigned       CNT_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [1:0]        Branch,
  input  logic [1:0]        Jump,
  input  logic              Equal,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_branch,
  input  logic [JUMP_W-1:0] in_j,
  input  logic [ADDR_W-1:0] in_jr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] link_pc,
  output logic              pc_bj,
  output logic [CNT_W-1:0]  b_taken_cnt,
  output logic [CNT_W-1:0]  b_fail_cnt,
  output logic [CNT_W-1:0]  j_cnt
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              bj_q, bj_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  logic              is_jump, is_branch, br_taken, redirect;
  logic [ADDR_W-1:0] target;

  // Jump encodings take priority; Branch is only looked at when Jump is 00.
  always_comb begin
    is_jump   = (Jump != 2'b00);
    is_branch = !is_jump && (Branch == 2'b01 || Branch == 2'b10);
    br_taken  = is_branch && ((Branch == 2'b01) ? Equal : !Equal);
    redirect  = is_jump || br_taken;
    if (Jump[1]) begin
      target = {in_pc[ADDR_W-1:JUMP_W], in_j};
    end else if (Jump[0]) begin
      target = in_jr;
    end else begin
      target = in_pc + in_branch + ADDR_W'(1);
    end
  end

  always_comb begin
    pc_d         = pc_q;
    bj_d         = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    if (!stall) begin
      pend_valid_d = 1'b0;
      if (redirect) begin
        pc_d = target;
        bj_d = 1'b1;
      end else if (pend_valid_q) begin
        pc_d = pend_tgt_q;
        bj_d = 1'b1;
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end else if (redirect) begin
      // Latest redirect seen during a stall is the one that survives.
      pend_valid_d = 1'b1;
      pend_tgt_d   = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      bj_q         <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      bj_q         <= bj_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end

  assign pc_out  = pc_q;
  assign pc_bj   = bj_q;
  assign link_pc = in_pc + ADDR_W'(1);

`ifdef PC_PERF_CNT_EN
  logic [CNT_W-1:0] b_taken_q, b_fail_q, j_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      b_taken_q <= '0;
      b_fail_q  <= '0;
      j_cnt_q   <= '0;
    end else if (!stall) begin
      if (is_jump && j_cnt_q != '1) begin
        j_cnt_q <= j_cnt_q + CNT_W'(1);
      end
      if (br_taken && b_taken_q != '1) begin
        b_taken_q <= b_taken_q + CNT_W'(1);
      end
      if (is_branch && !br_taken && b_fail_q != '1) begin
        b_fail_q <= b_fail_q + CNT_W'(1);
      end
    end
  end

  assign b_taken_cnt = b_taken_q;
  assign b_fail_cnt  = b_fail_q;
  assign j_cnt       = j_cnt_q;
`else
  assign b_taken_cnt = '0;
  assign b_fail_cnt  = '0;
  assign j_cnt       = '0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural model.
module tb_pc_next_unit;

  localparam int unsigned AW = 32;
  localparam int unsigned JW = 26;
  localparam int unsigned CW = 4;
`ifdef PC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, stall, Equal;
  logic [1:0]    Branch, Jump;
  logic [AW-1:0] in_pc, in_branch, in_jr;
  logic [JW-1:0] in_j;
  logic [AW-1:0] pc_out, link_pc;
  logic          pc_bj;
  logic [CW-1:0] b_taken_cnt, b_fail_cnt, j_cnt;

  pc_next_unit #(
    .ADDR_W  (AW),
    .JUMP_W  (JW),
    .CNT_W   (CW),
    .RESET_PC('0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .Branch     (Branch),
    .Jump       (Jump),
    .Equal      (Equal),
    .in_pc      (in_pc),
    .in_branch  (in_branch),
    .in_j       (in_j),
    .in_jr      (in_jr),
    .pc_out     (pc_out),
    .link_pc    (link_pc),
    .pc_bj      (pc_bj),
    .b_taken_cnt(b_taken_cnt),
    .b_fail_cnt (b_fail_cnt),
    .j_cnt      (j_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outcome of each decode packet, pending redirects held as a list.
  logic [AW-1:0] m_pc;
  bit            m_bj;
  logic [AW-1:0] m_pend[$];
  int            m_jc, m_bt, m_bf;

  // kind: 0 nothing, 1 jump, 2 taken branch, 3 untaken branch
  function automatic void decode(output bit redir, output logic [AW-1:0] tgt, output int kind);
    logic [AW-1:0] jt;
    redir = 1'b0;
    tgt   = '0;
    kind  = 0;
    jt    = {in_pc[AW-1:JW], in_j};
    if (Jump == 2'b11 || Jump == 2'b10) begin
      redir = 1'b1; tgt = jt; kind = 1;
    end else if (Jump == 2'b01) begin
      redir = 1'b1; tgt = in_jr; kind = 1;
    end else if (Branch == 2'b01 || Branch == 2'b10) begin
      if ((Branch == 2'b01 && Equal) || (Branch == 2'b10 && !Equal)) begin
        redir = 1'b1; tgt = in_pc + in_branch + 1; kind = 2;
      end else begin
        kind = 3;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit            r;
    logic [AW-1:0] t;
    int            k;
    if (rst) begin
      m_pc = '0; m_bj = 1'b0; m_pend.delete();
      m_jc = 0; m_bt = 0; m_bf = 0;
    end else begin
      decode(r, t, k);
      if (!stall) begin
        if (r) begin
          m_pc = t; m_bj = 1'b1;
        end else if (m_pend.size() > 0) begin
          m_pc = m_pend[$]; m_bj = 1'b1;
        end else begin
          m_pc = m_pc + 1; m_bj = 1'b0;
        end
        m_pend.delete();
        if (k == 1 && m_jc < CMAX) m_jc++;
        if (k == 2 && m_bt < CMAX) m_bt++;
        if (k == 3 && m_bf < CMAX) m_bf++;
      end else begin
        m_bj = 1'b0;
        if (r) m_pend.push_back(t);
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_out", pc_out, m_pc);
      check("pc_bj", 32'(pc_bj), 32'(m_bj));
      check("link_pc", link_pc, in_pc + 1);
      check("j_cnt", 32'(j_cnt), PERF ? m_jc : 0);
      check("b_taken_cnt", 32'(b_taken_cnt), PERF ? m_bt : 0);
      check("b_fail_cnt", 32'(b_fail_cnt), PERF ? m_bf : 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Branch = 2'b00; Jump = 2'b00; Equal = 1'b0;
    in_pc = '0; in_branch = '0; in_j = '0; in_jr = '0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    idle();
    cyc();
    chk_en = 1'b1;
    check("rst_pc", pc_out, 32'h0);
    check("rst_bj", 32'(pc_bj), 32'h0);
    check("rst_jcnt", 32'(j_cnt), 32'h0);
    rst = 1'b0;

    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("seq_pc", pc_out, 32'(i));
      check("seq_bj", 32'(pc_bj), 32'h0);
    end

    in_pc = 32'h10; Branch = 2'b01; Equal = 1'b1; in_branch = 32'hFFFF_FFFC;
    cyc();
    check("beq_pc", pc_out, 32'h0D);
    check("beq_bj", 32'(pc_bj), 32'h1);
    check("beq_cnt", 32'(b_taken_cnt), PERF ? 32'h1 : 32'h0);
    idle();
    cyc();
    check("beq_bj_drop", 32'(pc_bj), 32'h0);
    check("beq_pc_next", pc_out, 32'h0E);

    Branch = 2'b10; Equal = 1'b1;
    cyc();
    check("bne_fail_pc", pc_out, 32'h0F);
    check("bne_fail_cnt", 32'(b_fail_cnt), PERF ? 32'h1 : 32'h0);

    Branch = 2'b00; Jump = 2'b10; in_pc = 32'hFC00_0004; in_j = 26'h123;
    #1;
    check("jal_link", link_pc, 32'hFC00_0005);
    cyc();
    check("jal_pc", pc_out, 32'hFC00_0123);
    check("jal_cnt", 32'(j_cnt), PERF ? 32'h1 : 32'h0);

    idle();
    stall = 1'b1; Jump = 2'b01; in_jr = 32'h40;
    cyc();
    check("stall_hold", pc_out, 32'hFC00_0123);
    idle();
    cyc();
    cyc();
    check("stall_hold2", pc_out, 32'hFC00_0123);
    check("stall_bj", 32'(pc_bj), 32'h0);
    stall = 1'b0;
    cyc();
    check("pend_pc", pc_out, 32'h40);
    check("pend_bj", 32'(pc_bj), 32'h1);
    check("pend_jcnt", 32'(j_cnt), PERF ? 32'h1 : 32'h0);

    stall = 1'b1; Jump = 2'b01; in_jr = 32'h40;
    cyc();
    in_jr = 32'h80;
    cyc();
    idle();
    stall = 1'b0;
    cyc();
    check("pend_latest", pc_out, 32'h80);

    stall = 1'b1; Jump = 2'b01; in_jr = 32'h40;
    cyc();
    idle();
    rst = 1'b1;
    cyc();
    check("rst_pend_pc", pc_out, 32'h0);
    rst = 1'b0; stall = 1'b0;
    cyc();
    check("rst_pend_drop", pc_out, 32'h1);
    check("rst_pend_bj", 32'(pc_bj), 32'h0);

    Jump = 2'b11; in_j = 26'h5;
    for (int i = 0; i < 20; i++) cyc();
    check("jcnt_sat", 32'(j_cnt), PERF ? 32'(CMAX) : 32'h0);
    idle();

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      stall     = ($urandom_range(0, 2) == 0);
      Jump      = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      Branch    = 2'($urandom_range(0, 3));
      Equal     = 1'($urandom_range(0, 1));
      in_pc     = $urandom;
      in_branch = ($urandom_range(0, 1) == 0) ? 32'($signed(8'($urandom))) : $urandom;
      in_j      = 26'($urandom);
      in_jr     = $urandom;
      cyc();
    end

    rst = 1'b0; stall = 1'b0;
    idle();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
